// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the multiplexed seven-segment scanner:
//   NIBBLE_W      - width of one hex digit
//   DEF_TICK_DIV  - default clock cycles per digit slot
//   DEF_BLANK_CYC - default anti-ghosting blank cycles at the start of a slot
//   scan_state_t  - scan FSM state (BLANK, then DRIVE, within every slot)
// -----------------------------------------------------------------------------
package seven_seg_pkg;

   localparam int NIBBLE_W      = 4;
   localparam int DEF_TICK_DIV  = 50000;
   localparam int DEF_BLANK_CYC = 500;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

endpackage : seven_seg_pkg

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Slot timebase for the scanner. A counter runs 0..TICK_DIV-1 and wraps; each
// wrap ends one digit slot.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset (counter to 0)
//   slot_end  - high in the last cycle of a slot (counter == TICK_DIV-1)
//   blank_end - high in the last blank cycle of a slot (counter == BLANK_CYC-1)
// Both strobes are decoded from the counter register, so they are glitch-free
// with respect to the clock and line up with the cycle they describe.
// -----------------------------------------------------------------------------
module scan_tick_gen
   import seven_seg_pkg::*;
#(
   parameter int TICK_DIV  = DEF_TICK_DIV,   // >= 4
   parameter int BLANK_CYC = DEF_BLANK_CYC   // 1 <= BLANK_CYC < TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic slot_end,
   output logic blank_end
);

   localparam int CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0] cnt;

   assign slot_end  = (cnt == CNT_W'(TICK_DIV - 1));
   assign blank_end = (cnt == CNT_W'(BLANK_CYC - 1));

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (slot_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule : scan_tick_gen

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplexed driver for NUM_DIGITS hex digits. Each digit gets one slot
// of TICK_DIV cycles: BLANK_CYC cycles with every digit off (anti-ghosting),
// then the rest with only that digit enabled. A new value is taken through a
// one-deep valid/ready buffer and copied to the display only when the scan
// wraps back to digit 0, so a frame never shows a mix of old and new digits.
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   value_i      - hex value to show, digit 0 in the least significant nibble
//   load_valid   - value_i is offered this cycle
//   load_ready   - pending buffer empty (handshake = load_valid && load_ready)
//   digit_nibble - nibble of the active digit, to the 7-segment decoder
//   digit_en_n   - active-low digit enables, at most one low
//   frame_done   - one-cycle pulse with the first blank cycle of digit 0
// All outputs are registered and trail the internal state by one cycle.
// Build option: define SEVEN_SEG_LZ_BLANK_EN to suppress leading zeros
// (digit 0 is always driven).
// -----------------------------------------------------------------------------
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,              // 2..8
   parameter int TICK_DIV   = DEF_TICK_DIV,   // >= 4
   parameter int BLANK_CYC  = DEF_BLANK_CYC   // 1 <= BLANK_CYC < TICK_DIV
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0]   value_i,
   input  logic                             load_valid,
   output logic                             load_ready,
   output logic [NIBBLE_W-1:0]              digit_nibble,
   output logic [NUM_DIGITS-1:0]            digit_en_n,
   output logic                             frame_done
);

   localparam int                IDX_W    = $clog2(NUM_DIGITS);
   localparam int                DATA_W   = NIBBLE_W * NUM_DIGITS;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   scan_state_t         state;
   logic [IDX_W-1:0]    index;
   logic [DATA_W-1:0]   display_reg;
   logic [DATA_W-1:0]   pending;
   logic                frame_start;   // first cycle of a new frame (state view)

   logic                slot_end;
   logic                blank_end;
   logic                last_slot;
   logic                wrap;
   logic                handshake;
   logic [NIBBLE_W-1:0] nibble_sel;
   logic [NUM_DIGITS-1:0] en_drive;
   logic                lz_blank;

   scan_tick_gen #(
      .TICK_DIV  (TICK_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .slot_end  (slot_end),
      .blank_end (blank_end)
   );

   assign last_slot = (index == LAST_IDX);
   assign wrap      = slot_end && last_slot;
   assign handshake = load_valid && load_ready;

   // Digit select and enable pattern for the current index.
   // NOTE: every combinational output gets a default before the loop, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      nibble_sel = '0;
      en_drive   = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (index == IDX_W'(k)) begin
            nibble_sel  = display_reg[NIBBLE_W*k +: NIBBLE_W];
            en_drive[k] = 1'b0;
         end
      end
   end

`ifdef SEVEN_SEG_LZ_BLANK_EN
   // Walk from the most significant digit down; a digit is blanked while it
   // and everything above it is zero. Digit 0 is never part of the scan.
   always_comb begin : lz_scan
      logic zero_above;
      // NOTE: blocking assignments here, because zero_above is a running value
      // that each loop iteration must see updated immediately.
      zero_above = 1'b1;
      lz_blank   = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above && (display_reg[NIBBLE_W*k +: NIBBLE_W] == '0);
         if (index == IDX_W'(k)) begin
            lz_blank = zero_above;
         end
      end
   end
`else
   assign lz_blank = 1'b0;
`endif

   // Scan FSM plus the registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_BLANK;
         index        <= '0;
         frame_start  <= 1'b0;
         digit_en_n   <= '1;
         digit_nibble <= '0;
         frame_done   <= 1'b0;
      end else begin
         if (slot_end) begin
            state <= ST_BLANK;
            index <= last_slot ? '0 : index + IDX_W'(1);
         end else if (state == ST_BLANK && blank_end) begin
            state <= ST_DRIVE;
         end
         // frame_done is delayed once more so it lands on the same cycle the
         // outputs show digit 0 blanking, not the cycle the state gets there.
         frame_start  <= wrap;
         frame_done   <= frame_start;
         digit_en_n   <= (state == ST_DRIVE && !lz_blank) ? en_drive : '1;
         digit_nibble <= nibble_sel;
      end
   end

   // Load buffer. load_ready doubles as the "pending empty" flag. A commit
   // needs the buffer already full when the wrap edge arrives, so a handshake
   // on that same edge waits for the following wrap. Commit and handshake are
   // mutually exclusive because one needs load_ready low and the other high.
   // NOTE: display_reg and pending are reset explicitly so a reset mid-load
   // throws the buffered value away instead of committing stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display_reg <= '0;
         pending     <= '0;
         load_ready  <= 1'b1;
      end else if (wrap && !load_ready) begin
         display_reg <= pending;
         load_ready  <= 1'b1;
      end else if (handshake) begin
         pending     <= value_i;
         load_ready  <= 1'b0;
      end
   end

endmodule : seven_seg_scanner

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
// Self-checking bench for seven_seg_scanner with NUM_DIGITS=4, TICK_DIV=8,
// BLANK_CYC=2. Expected behaviour is derived from the cycle number t since
// reset release: state cycle u has counter u%8 and digit (u/8)%4, and every
// output at cycle t reflects state cycle t-1. Accepted loads are queued with
// the cycle their commit becomes visible; the queue is popped at that cycle.
// Honours SEVEN_SEG_LZ_BLANK_EN for the leading-zero expectations.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

   localparam int ND   = 4;
   localparam int TDIV = 8;
   localparam int BLNK = 2;
   localparam int FRM  = ND * TDIV;

   typedef struct {
      logic [15:0] val;
      int          due;   // cycle at which the committed value is in display_reg
   } commit_t;

   logic          clk;
   logic          rst_n;
   logic [15:0]   value_i;
   logic          load_valid;
   logic          load_ready;
   logic [3:0]    digit_nibble;
   logic [ND-1:0] digit_en_n;
   logic          frame_done;

   int            t;
   int            errors;
   int            checks;
   logic          pend_exp;
   logic          last_hs;
   logic [15:0]   disp_cur;
   logic [15:0]   disp_prev;
   commit_t       sb_q[$];

   seven_seg_scanner #(
      .NUM_DIGITS (ND),
      .TICK_DIV   (TDIV),
      .BLANK_CYC  (BLNK)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .value_i      (value_i),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .digit_nibble (digit_nibble),
      .digit_en_n   (digit_en_n),
      .frame_done   (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0d", tag, got, exp, t);
      end
   endtask

   task automatic model_reset();
      t         = 0;
      pend_exp  = 1'b0;
      disp_cur  = '0;
      disp_prev = '0;
      sb_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_en"},    32'(digit_en_n),   32'hF);
      check({tag, "_nib"},   32'(digit_nibble), 32'h0);
      check({tag, "_ready"}, 32'(load_ready),   32'h1);
      check({tag, "_fdone"}, 32'(frame_done),   32'h0);
   endtask

   // Advance one cycle: record a handshake for the coming edge, then compare
   // all outputs in the middle of the new cycle.
   task automatic step();
      commit_t    cm;
      int         u;
      int         c;
      int         s;
      logic [3:0] e;
      last_hs = 1'b0;
      if (load_valid && !pend_exp) begin
         cm.val = value_i;
         cm.due = ((t + 2 + FRM - 1) / FRM) * FRM;
         sb_q.push_back(cm);
         pend_exp = 1'b1;
         last_hs  = 1'b1;
      end
      @(negedge clk);
      t++;
      disp_prev = disp_cur;
      if (sb_q.size() > 0 && sb_q[0].due == t) begin
         cm       = sb_q.pop_front();
         disp_cur = cm.val;
         pend_exp = 1'b0;
      end
      u = t - 1;
      c = u % TDIV;
      s = (u / TDIV) % ND;
      e = 4'hF;
      if (c >= BLNK) begin
         e[s] = 1'b0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
         if (s > 0 && (disp_prev >> (4 * s)) == 16'h0) e = 4'hF;
`endif
      end
      check("digit_en_n",   32'(digit_en_n),   32'(e));
      check("digit_nibble", 32'(digit_nibble), 32'((disp_prev >> (4 * s)) & 16'hF));
      check("load_ready",   32'(load_ready),   32'(!pend_exp));
      check("frame_done",   32'(frame_done),   32'((t > FRM) && (t % FRM == 1)));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Advance until t lands on the given position within a frame (bounded).
   task automatic wait_mod(input int m);
      int n;
      n = 0;
      while ((t % FRM) != m && n < 2 * FRM) begin
         step();
         n++;
      end
      check("sync_pos", 32'(t % FRM), 32'(m));
   endtask

   task automatic load_once(input logic [15:0] v);
      value_i    = v;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
   endtask

   initial begin
      int n;
      errors     = 0;
      checks     = 0;
      rst_n      = 1'b0;
      load_valid = 1'b0;
      value_i    = '0;
      model_reset();

      // Reset values while rst_n is held low.
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      model_reset();

      // Idle scan: two frames of the all-zero display.
      run(2 * FRM);

      // Load mid-frame; commits at the next wrap.
      wait_mod(10);
      load_once(16'h1234);
      run(2 * FRM + 6);

      // Second value offered while the buffer is full is ignored until ready.
      wait_mod(5);
      load_once(16'hAAAA);
      value_i    = 16'hBBBB;
      load_valid = 1'b1;
      n = 0;
      while (!last_hs && n < 3 * FRM) begin
         step();
         n++;
      end
      check("bbbb_accepted", 32'(last_hs), 32'h1);
      load_valid = 1'b0;
      run(2 * FRM + 4);

      // Handshake in the wrap cycle: commit slips one full frame.
      wait_mod(FRM - 1);
      load_once(16'h00F0);
      run(3 * FRM);

      // Leading-zero cases.
      wait_mod(3);
      load_once(16'h0005);
      run(2 * FRM + 4);
      wait_mod(3);
      load_once(16'h0000);
      run(2 * FRM + 4);

      // Reset during DRIVE of digit 2 with the buffer full.
      wait_mod(17);
      load_once(16'h9876);
      wait_mod(2 * TDIV + 4);
      check("pend_full_pre_reset", 32'(load_ready), 32'h0);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run(2 * FRM + 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_seven_seg_scanner
